// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative divider (div_iter).
// `WORD_WIDTH normally comes from define.v; it falls back to 32 here so the
// package is self-contained when define.v is not part of the file list.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package div_iter_pkg;

    localparam int unsigned WORD_W = `WORD_WIDTH;
    localparam int unsigned POS_W  = $clog2(WORD_W);

    // Quotient returned for a zero divisor (all ones)
    localparam logic [WORD_W-1:0] DIV0_QUOT = '1;
    // Most negative two's-complement word, the only signed overflow dividend
    localparam logic [WORD_W-1:0] SMIN      = {1'b1, {(WORD_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Request captured at acceptance
    typedef struct packed {
        logic [WORD_W-1:0] dividend;
        logic [WORD_W-1:0] divisor;
        logic              is_signed;
        logic              want_rem;
    } div_req_t;

    // Two's-complement negate when en is set
    function automatic logic [WORD_W-1:0] neg_if(input logic [WORD_W-1:0] v, input logic en);
        return en ? ((~v) + WORD_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_find_ones.sv
// Leading-one detector: bit index of the most significant set bit (0 for zero input).
module div_find_ones
    import div_iter_pkg::*;
(
    input  logic [WORD_W-1:0] value,
    output logic [POS_W-1:0]  pos_c
);

    // Scan upward so the highest set bit wins
    always_comb begin
        pos_c = '0;
        for (int i = 0; i < WORD_W; i++) begin
            if (value[i]) pos_c = POS_W'(i);
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle (DIV/DIVU/REM/REMU).
// Optional macro DIV_EARLY_OUT_EN: enables leading-one skip and the
// |divisor| > |dividend| early-out; without it every normal op runs 32 steps.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned TAG_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_dividend,
    input  logic [WORD_W-1:0] in_divisor,
    input  logic              in_signed,
    input  logic              in_rem,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned DVS_W = 2 * WORD_W;

    state_e              state_q, state_d;
    div_req_t            req_q, req_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [WORD_W-1:0]   rem_q, rem_d;
    logic [DVS_W-1:0]    dvs_q, dvs_d;
    logic [WORD_W-1:0]   quot_q, quot_d;
    logic [POS_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_result_q, out_result_d;
    logic [TAG_W-1:0]    out_tag_q, out_tag_d;
    logic                in_ready_q, in_ready_d;

    logic                dvd_neg_c, dvs_neg_c;
    logic [WORD_W-1:0]   dvd_mag_c, dvs_mag_c;
    logic                div_zero_c, ovf_c, small_c, special_c;
    logic [POS_W-1:0]    shift_c;
    logic [WORD_W-1:0]   spec_quot_c, spec_rem_c;
    logic                step_ge_c;
    logic [WORD_W-1:0]   quot_fix_c, rem_fix_c;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

    // Operand magnitudes and special-case detection on the captured request
    always_comb begin
        dvd_neg_c   = req_q.is_signed & req_q.dividend[WORD_W-1];
        dvs_neg_c   = req_q.is_signed & req_q.divisor[WORD_W-1];
        dvd_mag_c   = neg_if(req_q.dividend, dvd_neg_c);
        dvs_mag_c   = neg_if(req_q.divisor, dvs_neg_c);
        div_zero_c  = (req_q.divisor == '0);
        ovf_c       = req_q.is_signed && (req_q.dividend == SMIN) && (req_q.divisor == '1);
        special_c   = div_zero_c | ovf_c | small_c;
        spec_quot_c = div_zero_c ? DIV0_QUOT : (ovf_c ? SMIN : '0);
        spec_rem_c  = ovf_c ? '0 : req_q.dividend;
    end

`ifdef DIV_EARLY_OUT_EN
    logic [POS_W-1:0] dvd_pos_c, dvs_pos_c;

    div_find_ones u_ones_dvd (.value(dvd_mag_c), .pos_c(dvd_pos_c));
    div_find_ones u_ones_dvs (.value(dvs_mag_c), .pos_c(dvs_pos_c));

    // Align divisor's leading one with the dividend's; skip when divisor is larger
    assign shift_c = dvd_pos_c - dvs_pos_c;
    assign small_c = (dvs_mag_c > dvd_mag_c);
`else
    // Full-width iteration: always 32 restoring steps
    assign shift_c = POS_W'(WORD_W - 1);
    assign small_c = 1'b0;
`endif

    // Restoring step and final sign correction
    always_comb begin
        step_ge_c  = ({WORD_W'(0), rem_q} >= dvs_q);
        quot_fix_c = neg_if(quot_q, dvd_neg_c ^ dvs_neg_c);
        rem_fix_c  = neg_if(rem_q, dvd_neg_c);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid && in_ready_q) state_d = ST_PREP;
            ST_PREP: state_d = special_c ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Datapath and registered outputs
    always_comb begin
        req_d        = req_q;
        tag_d        = tag_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        quot_d       = quot_q;
        cnt_d        = cnt_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q && !flush) begin
                    req_d = '{dividend: in_dividend, divisor: in_divisor,
                              is_signed: in_signed, want_rem: in_rem};
                    tag_d = in_tag;
                end
            end
            ST_PREP: begin
                rem_d  = dvd_mag_c;
                dvs_d  = {{WORD_W{1'b0}}, dvs_mag_c} << shift_c;
                quot_d = '0;
                cnt_d  = shift_c;
                if (special_c) begin
                    cnt_d        = '0;
                    out_result_d = req_q.want_rem ? spec_rem_c : spec_quot_c;
                    out_tag_d    = tag_q;
                end
            end
            ST_CALC: begin
                if (step_ge_c) rem_d = rem_q - dvs_q[WORD_W-1:0];
                quot_d = {quot_q[WORD_W-2:0], step_ge_c};
                dvs_d  = dvs_q >> 1;
                cnt_d  = (cnt_q == '0) ? '0 : cnt_q - POS_W'(1);
            end
            ST_FIX: begin
                out_result_d = req_q.want_rem ? rem_fix_c : quot_fix_c;
                out_tag_d    = tag_q;
            end
            default: ;
        endcase
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= '0;
            tag_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            quot_q       <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            req_q        <= req_d;
            tag_q        <= tag_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            quot_q       <= quot_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            in_ready_q   <= in_ready_d;
        end
    end

endmodule
